// File: rtl/risc_control_fsm.sv
// Sequencing controller for the Simple RISC Machine: a Moore FSM that steps the datapath
// through register fetch, ALU compute and write-back for the latched {opcode, op}.
module risc_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [2:0] nsel,
  output logic [3:0] vsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       write,
  output logic       illegal
);

  typedef enum logic [2:0] {
    StWait,
    StDecode,
    StGetA,
    StGetB,
    StCompute,
    StWriteReg,
    StWriteImm
  } state_e;

  localparam logic [4:0] CodeMovImm = 5'b110_10;
  localparam logic [4:0] CodeMovReg = 5'b110_00;
  localparam logic [4:0] CodeMvn    = 5'b101_11;
  localparam logic [4:0] CodeAdd    = 5'b101_00;
  localparam logic [4:0] CodeCmp    = 5'b101_01;
  localparam logic [4:0] CodeAnd    = 5'b101_10;

  localparam logic [2:0] NselNone = 3'b000;
  localparam logic [2:0] NselRn   = 3'b001;
  localparam logic [2:0] NselRd   = 3'b010;
  localparam logic [2:0] NselRm   = 3'b100;

  localparam logic [3:0] VselC     = 4'b0001;
  localparam logic [3:0] VselImm8  = 4'b0100;

  state_e     r_state;
  state_e     w_state_next;
  logic [4:0] r_code;
  logic       w_code_illegal;
  logic       w_unary;

  // State register: reset forces WAIT without a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StWait;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The code is captured only on the accepting WAIT edge, so the decoder may
  // change its opcode/op inputs freely while an instruction is in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_code <= 5'b000_00;
    end else if ((r_state == StWait) && s) begin
      r_code <= {opcode, op};
    end
  end

  always_comb begin
    w_code_illegal = 1'b0;
    unique case (r_code)
      CodeMovImm, CodeMovReg, CodeMvn, CodeAdd, CodeCmp, CodeAnd: w_code_illegal = 1'b0;
      default:                                                     w_code_illegal = 1'b1;
    endcase
  end

  // MOV-reg and MVN are single-operand: A side is forced to zero.
  assign w_unary = (r_code == CodeMovReg) || (r_code == CodeMvn);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StWait: begin
        if (s) begin
          w_state_next = StDecode;
        end
      end
      StDecode: begin
        unique case (r_code)
          CodeMovImm:                w_state_next = StWriteImm;
          CodeMovReg, CodeMvn:       w_state_next = StGetB;
          CodeAdd, CodeCmp, CodeAnd: w_state_next = StGetA;
          default:                   w_state_next = StWait;
        endcase
      end
      StGetA:     w_state_next = StGetB;
      StGetB:     w_state_next = StCompute;
      StCompute:  w_state_next = (r_code == CodeCmp) ? StWait : StWriteReg;
      StWriteReg: w_state_next = StWait;
      StWriteImm: w_state_next = StWait;
      default:    w_state_next = StWait;
    endcase
  end

  // Outputs are qualified by reset so an in-flight write is dropped the instant reset asserts.
  always_comb begin
    w       = 1'b0;
    nsel    = NselNone;
    vsel    = 4'b0000;
    loada   = 1'b0;
    loadb   = 1'b0;
    loadc   = 1'b0;
    loads   = 1'b0;
    asel    = 1'b0;
    bsel    = 1'b0;
    write   = 1'b0;
    illegal = 1'b0;
    if (!reset) begin
      w = 1'b1;
    end else begin
      unique case (r_state)
        StWait: begin
          w = 1'b1;
        end
        StDecode: begin
          illegal = w_code_illegal;
        end
        StGetA: begin
          nsel  = NselRn;
          loada = 1'b1;
        end
        StGetB: begin
          nsel  = NselRm;
          loadb = 1'b1;
        end
        StCompute: begin
          asel = w_unary;
          if (r_code == CodeCmp) begin
            loads = 1'b1;
          end else begin
            loadc = 1'b1;
          end
        end
        StWriteReg: begin
          nsel  = NselRd;
          vsel  = VselC;
          write = 1'b1;
        end
        StWriteImm: begin
          nsel  = NselRn;
          vsel  = VselImm8;
          write = 1'b1;
        end
        default: begin
          w = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_risc_control_fsm.sv
// Scoreboard bench for risc_control_fsm: per-cycle expected output vectors are queued
// when an instruction is started and compared one per clock, 1 time unit after each edge.
module tb_risc_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w;
  logic [2:0] nsel;
  logic [3:0] vsel;
  logic       loada, loadb, loadc, loads, asel, bsel, write, illegal;

  risc_control_fsm dut (
    .clk     (clk),
    .reset   (reset),
    .s       (s),
    .opcode  (opcode),
    .op      (op),
    .w       (w),
    .nsel    (nsel),
    .vsel    (vsel),
    .loada   (loada),
    .loadb   (loadb),
    .loadc   (loadc),
    .loads   (loads),
    .asel    (asel),
    .bsel    (bsel),
    .write   (write),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  // Packed view: {w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write, illegal}
  logic [15:0] obs;
  assign obs = {w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write, illegal};

  logic [15:0] exp_q[$];
  logic [4:0]  pend_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic logic [15:0] vec(input logic w_e, input logic [2:0] ns, input logic [3:0] vs,
                                      input logic la, input logic lb, input logic lc,
                                      input logic ls, input logic as, input logic bs,
                                      input logic wr, input logic il);
    return {w_e, ns, vs, la, lb, lc, ls, as, bs, wr, il};
  endfunction

  task automatic check_out(input string tag, input logic [15:0] got, input logic [15:0] exp_v);
    n_cmp++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (w nsel vsel la lb lc ls as bs wr il)",
               tag, got, exp_v);
    end
  endtask

  // Expected outputs after each edge of one instruction, ending with the WAIT state.
  task automatic push_seq(input logic [4:0] code);
    logic [15:0] v_wait, v_dec, v_ill, v_geta, v_getb, v_cmp_alu, v_cmp_un, v_cmp_s, v_wreg, v_wimm;
    v_wait    = vec(1, 3'b000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
    v_dec     = vec(0, 3'b000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
    v_ill     = vec(0, 3'b000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 1);
    v_geta    = vec(0, 3'b001, 4'b0000, 1, 0, 0, 0, 0, 0, 0, 0);
    v_getb    = vec(0, 3'b100, 4'b0000, 0, 1, 0, 0, 0, 0, 0, 0);
    v_cmp_alu = vec(0, 3'b000, 4'b0000, 0, 0, 1, 0, 0, 0, 0, 0);
    v_cmp_un  = vec(0, 3'b000, 4'b0000, 0, 0, 1, 0, 1, 0, 0, 0);
    v_cmp_s   = vec(0, 3'b000, 4'b0000, 0, 0, 0, 1, 0, 0, 0, 0);
    v_wreg    = vec(0, 3'b010, 4'b0001, 0, 0, 0, 0, 0, 0, 1, 0);
    v_wimm    = vec(0, 3'b001, 4'b0100, 0, 0, 0, 0, 0, 0, 1, 0);
    case (code)
      5'b110_10: begin
        exp_q.push_back(v_dec); exp_q.push_back(v_wimm);
      end
      5'b110_00, 5'b101_11: begin
        exp_q.push_back(v_dec); exp_q.push_back(v_getb);
        exp_q.push_back(v_cmp_un); exp_q.push_back(v_wreg);
      end
      5'b101_00, 5'b101_10: begin
        exp_q.push_back(v_dec); exp_q.push_back(v_geta); exp_q.push_back(v_getb);
        exp_q.push_back(v_cmp_alu); exp_q.push_back(v_wreg);
      end
      5'b101_01: begin
        exp_q.push_back(v_dec); exp_q.push_back(v_geta); exp_q.push_back(v_getb);
        exp_q.push_back(v_cmp_s);
      end
      default: exp_q.push_back(v_ill);
    endcase
    exp_q.push_back(v_wait);
  endtask

  // Starts pend_q[0] from WAIT; each further code is launched by holding s in the WAIT cycle.
  task automatic run_codes(input string tag);
    logic [15:0] e;
    @(negedge clk);
    s = 1'b1;
    {opcode, op} = pend_q.pop_front();
    @(posedge clk); #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_out(tag, obs, e);
      if (e[15]) begin
        if (pend_q.size() > 0) begin
          s = 1'b1;
          {opcode, op} = pend_q.pop_front();
        end else begin
          s = 1'b0;
        end
      end else begin
        // s and the decoder fields are don't-care outside WAIT
        s = 1'($urandom_range(0, 1));
        {opcode, op} = 5'($urandom);
      end
      if (exp_q.size() > 0) begin
        @(posedge clk); #1;
      end
    end
    s = 1'b0;
  endtask

  task automatic run_one(input logic [4:0] code, input string tag);
    push_seq(code);
    pend_q.push_back(code);
    run_codes(tag);
  endtask

  logic [15:0] v_idle;
  logic [15:0] v_compute_add;

  initial begin
    v_idle        = vec(1, 3'b000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
    v_compute_add = vec(0, 3'b000, 4'b0000, 0, 0, 1, 0, 0, 0, 0, 0);
    reset  = 1'b0;
    s      = 1'b0;
    opcode = 3'b000;
    op     = 2'b00;
    #1;
    check_out("reset_state", obs, v_idle);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check_out("idle_no_s", obs, v_idle);
    end

    run_one(5'b110_10, "mov_imm");
    run_one(5'b101_00, "add");
    run_one(5'b101_01, "cmp");
    run_one(5'b101_11, "mvn");
    run_one(5'b110_00, "mov_reg");
    run_one(5'b101_10, "and");
    run_one(5'b111_00, "illegal_111_00");
    run_one(5'b000_00, "illegal_000_00");
    run_one(5'b110_01, "illegal_110_01");

    // Back-to-back with s held high through each WAIT cycle.
    pend_q.push_back(5'b110_10); push_seq(5'b110_10);
    pend_q.push_back(5'b101_00); push_seq(5'b101_00);
    pend_q.push_back(5'b011_11); push_seq(5'b011_11);
    pend_q.push_back(5'b101_01); push_seq(5'b101_01);
    run_codes("chain");

    // ADD aborted by reset during COMPUTE.
    @(negedge clk);
    s = 1'b1;
    {opcode, op} = 5'b101_00;
    @(posedge clk); #1;
    s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_out("abort_pre_compute", obs, v_compute_add);
    #2;
    reset = 1'b0;
    #1;
    check_out("abort_async", obs, v_idle);
    repeat (3) begin
      @(posedge clk); #1;
      check_out("abort_hold", obs, v_idle);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_out("abort_release", obs, v_idle);

    run_one(5'b101_11, "post_reset_mvn");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/risc_control_fsm.md
# risc_control_fsm

Moore-style sequencing controller for the Simple RISC Machine CPU. It accepts a start strobe and the decoded opcode/op fields, then steps the datapath through register fetch, ALU compute and write-back. It drives the register-file, pipeline-register, mux and status-load controls, plus the `nsel` select into the instruction decoder. It sits between the instruction register/decoder and the datapath inside `cpu`, and signals completion through `w`.

## Interface
- No parameters. Encodings are fixed, as defined below.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset. 0 = reset.
- `s` in 1: start strobe. Sampled only in WAIT.
- `opcode` in 3: instruction opcode from the decoder.
- `op` in 2: instruction sub-op from the decoder.
- `w` out 1: 1 while in WAIT, meaning idle and ready.
- `nsel` out 3: one-hot register-field select to the decoder. 001 = Rn, 010 = Rd, 100 = Rm, 000 = none.
- `vsel` out 4: one-hot write-back source. 0001 = C (`datapath_out`), 0010 = PC, 0100 = `sximm8`, 1000 = `mdata`.
- `loada`, `loadb`, `loadc`, `loads` out 1 each: datapath register enables.
- `asel`, `bsel` out 1 each: 1 selects zero (A side) or `sximm5` (B side).
- `write` out 1: register-file write enable.
- `illegal` out 1: one-cycle pulse for an unsupported opcode/op.

## Operation
- States: WAIT, DECODE, GET_A, GET_B, COMPUTE, WRITE_REG, WRITE_IMM.
- Outputs depend only on state and the latched `{opcode,op}`.
- Every output not listed for a state is 0.
- WAIT
  - Outputs: `w`=1.
  - If `s`=1: latch `{opcode,op}` into an internal 5-bit register and go to DECODE. Otherwise stay.
- DECODE
  - No outputs asserted, except `illegal`=1 when the code is unsupported.
  - Routes on the latched code:
    - 110_10 (MOV Rn,#imm8) -> WRITE_IMM.
    - 110_00 (MOV Rd,Rm{,sh}) -> GET_B.
    - 101_11 (MVN) -> GET_B.
    - 101_00 (ADD), 101_01 (CMP), 101_10 (AND) -> GET_A.
    - Any other code -> WAIT.
- GET_A
  - Outputs: `nsel`=001, `loada`=1.
  - Next: GET_B.
- GET_B
  - Outputs: `nsel`=100, `loadb`=1.
  - Next: COMPUTE.
- COMPUTE
  - Outputs: `bsel`=0.
  - `asel`=1 for MOV-reg and MVN; `asel`=0 otherwise.
  - CMP: `loads`=1, `loadc`=0, then go to WAIT.
  - All others: `loadc`=1, `loads`=0, then go to WRITE_REG.
- WRITE_REG
  - Outputs: `nsel`=010, `vsel`=0001, `write`=1.
  - Next: WAIT.
- WRITE_IMM
  - Outputs: `nsel`=001, `vsel`=0100, `write`=1.
  - Next: WAIT.
- ALUop and shift come from the decoder directly. This block does not drive them.
- The controller never writes while `w`=1.
- `s` outside WAIT is ignored. There is no queueing.
- The instruction register must not be reloaded while `w`=0. Register-number fields are still read through the decoder.

## Timing
- Reset (`reset`=0): state becomes WAIT immediately, without waiting for a clock edge.
  - `w`=1; all other outputs 0; latched code 000_00.
  - A write in flight is aborted combinationally.
- Counting the WAIT edge where `s`=1 is sampled as edge 0, `w` returns high at edge N:
  - MOV imm: N=2. DECODE, then WRITE_IMM.
  - MOV reg and MVN: N=4.
  - ADD and AND: N=5.
  - CMP: N=4. Status flags update at edge 4.
  - Illegal: N=1. `illegal` is high during the single DECODE cycle.
- If `s` is held high on return to WAIT, the next instruction starts at the following edge. `w` is high for exactly one cycle.
- The register-file write occurs at the edge that ends WRITE_REG or WRITE_IMM.
- `loadc`/`loads` take effect at the edge that ends COMPUTE.
- Reset released synchronously to `clk` (setup met): the FSM stays in WAIT until `s` is sampled.

## Test plan
- Reset: assert `reset`=0 mid-simulation -> `w`=1, `write`=0, `nsel`=000, `vsel`=0000 with no clock edge. Hold for 3 clocks -> state unchanged.
- MOV R0,#7 (opcode 110, op 10), one-cycle `s` -> `nsel`=001 and `vsel`=0100 with `write`=1 for exactly one cycle. `w` high at edge 2. Datapath R0=7.
- ADD R2,R1,R0 (101_00, R0=7, R1=2) -> `loada` (`nsel`=001), `loadb` (`nsel`=100), `loadc`, write (`nsel`=010, `vsel`=0001) in consecutive cycles. `w` high at edge 5. R2=9.
- CMP R0,R0 (101_01) -> `loads`=1 at COMPUTE; `write` never asserted. `w` at edge 4. Z=1, N=0, V=0.
- MVN R3,R0 (101_11) -> no GET_A cycle, `asel`=1 in COMPUTE. `w` at edge 4. R3=16'hFFF8.
- Illegal 111_00 -> `illegal`=1 for one cycle, no loads or writes, `w` at edge 1. Separately: ADD with `reset`=0 during COMPUTE -> immediate WAIT, `loadc`=0, destination register unchanged.
